readout_sequencer: RTL and testbench

Frame sequencer for the readout chip and its ADCs, placed in the master FPGA. Each frame it runs the correlated-double-sampling cycle on the readout chip: reset, sample the reset level, integrate, then sample the signal level. It then steps through every channel with STI/CLK_READOUT. For each channel it issues a simultaneous conversion start to the four ADC nodes and waits until all four report completion. It keeps the frame count and a sticky ADC-timeout flag for the host.

---
 rtl/readout_sequencer.sv | 135 +++++++++++++
 tb/tb_readout_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/readout_sequencer.sv
// Frame sequencer for the readout chip: correlated-double-sampling cycle, then per-channel
// readout with a simultaneous four-node ADC conversion handshake and a sticky timeout flag.
module readout_sequencer #(
  parameter int unsigned NUM_CH      = 64,
  parameter int unsigned RST_CYC     = 16,
  parameter int unsigned SH_CYC      = 8,
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned ADC_TIMEOUT = 255,
  localparam int unsigned CW         = $clog2(NUM_CH)
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          run_i,
  input  logic [15:0]   intg_cyc_i,
  input  logic [3:0]    adc_done_i,
  output logic          intg_o,
  output logic          irst_o,
  output logic          shs_o,
  output logic          shr_o,
  output logic          sti_o,
  output logic          clk_readout_o,
  output logic [3:0]    start_adc_o,
  output logic [CW-1:0] ch_index_o,
  output logic [15:0]   frame_cnt_o,
  output logic          frame_done_o,
  output logic          busy_o,
  output logic          timeout_err_o
);

  localparam logic [15:0]   RstLast    = 16'(RST_CYC - 1);
  localparam logic [15:0]   ShLast     = 16'(SH_CYC - 1);
  localparam logic [15:0]   SettleLast = 16'(SETTLE_CYC - 1);
  localparam logic [15:0]   TmoLast    = 16'(ADC_TIMEOUT - 1);
  localparam logic [CW-1:0] ChLast     = CW'(NUM_CH - 1);

  typedef enum logic [3:0] {
    StIdle, StRst, StShr, StInteg, StShs, StSti, StSettle, StConv, StAdv, StDone
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   cnt_q;
  logic [15:0]   intg_q;
  logic [15:0]   intg_last;
  logic [3:0]    mask_q, mask_d;
  logic          tmo;
  logic          irst_q, shr_q, intg_q_out, shs_q, sti_q, clk_ro_q;
  logic          start_adc_q;
  logic [CW-1:0] ch_q;
  logic [15:0]   frame_cnt_q;
  logic          frame_done_q, busy_q, timeout_err_q;

  // A zero integration length still gives one INTG cycle.
  assign intg_last = (intg_q == 16'd0) ? 16'd0 : intg_q - 16'd1;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    tmo     = 1'b0;
    unique case (state_q)
      StIdle:   if (run_i) state_d = StRst;
      StRst:    if (cnt_q == RstLast) state_d = StShr;
      StShr:    if (cnt_q == ShLast) state_d = StInteg;
      StInteg:  if (cnt_q == intg_last) state_d = StShs;
      StShs:    if (cnt_q == ShLast) state_d = StSti;
      StSti:    state_d = StSettle;
      StSettle: if (cnt_q == SettleLast) state_d = StConv;
      StConv: begin
        // Done pulses coinciding with start_adc belong to no conversion of ours.
        mask_d = start_adc_q ? 4'h0 : (mask_q | adc_done_i);
        if (mask_d != 4'hF && cnt_q == TmoLast) tmo = 1'b1;
        if (mask_d == 4'hF || tmo) state_d = (ch_q == ChLast) ? StDone : StAdv;
      end
      StAdv:    state_d = StSettle;
      StDone:   state_d = run_i ? StRst : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      intg_q        <= '0;
      mask_q        <= '0;
      irst_q        <= 1'b0;
      shr_q         <= 1'b0;
      intg_q_out    <= 1'b0;
      shs_q         <= 1'b0;
      sti_q         <= 1'b0;
      clk_ro_q      <= 1'b0;
      start_adc_q   <= 1'b0;
      ch_q          <= '0;
      frame_cnt_q   <= '0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q || state_d == StIdle) ? 16'd0 : cnt_q + 16'd1;
      mask_q  <= mask_d;
      if (state_d == StRst && state_q != StRst) intg_q <= intg_cyc_i;
      irst_q       <= (state_d == StRst);
      shr_q        <= (state_d == StShr);
      intg_q_out   <= (state_d == StInteg);
      shs_q        <= (state_d == StShs);
      sti_q        <= (state_d == StSti);
      clk_ro_q     <= (state_d == StSti) || (state_d == StAdv);
      start_adc_q  <= (state_d == StConv) && (state_q != StConv);
      frame_done_q <= (state_d == StDone);
      busy_q       <= (state_d != StIdle);
      if (state_d == StSti) begin
        ch_q <= '0;
      end else if (state_d == StAdv && state_q != StAdv) begin
        ch_q <= ch_q + 1'b1;
      end
      if (state_d == StDone && state_q != StDone) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (tmo) timeout_err_q <= 1'b1;
    end
  end

  assign irst_o        = irst_q;
  assign shr_o         = shr_q;
  assign intg_o        = intg_q_out;
  assign shs_o         = shs_q;
  assign sti_o         = sti_q;
  assign clk_readout_o = clk_ro_q;
  assign start_adc_o   = {4{start_adc_q}};
  assign ch_index_o    = ch_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign frame_done_o  = frame_done_q;
  assign busy_o        = busy_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// Bench for readout_sequencer: a frame-level model expands each frame into per-cycle expected
// outputs; an ADC responder answers start_adc with per-node scheduled done pulses.
module tb_readout_sequencer;

  localparam int NCH  = 4;
  localparam int RSTC = 4;
  localparam int SHC  = 2;
  localparam int STL  = 2;
  localparam int TMO  = 20;

  logic        clk, reset_n, run;
  logic [15:0] intg_cyc;
  logic [3:0]  adc_done;
  logic        intg_s, irst_s, shs_s, shr_s, sti_s, clkr_s;
  logic [3:0]  start_adc;
  logic [1:0]  ch_index;
  logic [15:0] frame_cnt;
  logic        frame_done, busy, timeout_err;

  readout_sequencer #(
    .NUM_CH      (NCH),
    .RST_CYC     (RSTC),
    .SH_CYC      (SHC),
    .SETTLE_CYC  (STL),
    .ADC_TIMEOUT (TMO)
  ) dut (
    .clk_i         (clk),
    .reset_ni      (reset_n),
    .run_i         (run),
    .intg_cyc_i    (intg_cyc),
    .adc_done_i    (adc_done),
    .intg_o        (intg_s),
    .irst_o        (irst_s),
    .shs_o         (shs_s),
    .shr_o         (shr_s),
    .sti_o         (sti_s),
    .clk_readout_o (clkr_s),
    .start_adc_o   (start_adc),
    .ch_index_o    (ch_index),
    .frame_cnt_o   (frame_cnt),
    .frame_done_o  (frame_done),
    .busy_o        (busy),
    .timeout_err_o (timeout_err)
  );

  typedef struct packed {
    logic        irst, shr, intg, shs, sti, clkr;
    logic [3:0]  start;
    logic [1:0]  ch;
    logic [15:0] fcnt;
    logic        fdone, busy, err;
  } vec_t;

  vec_t        exp_q[$];
  int          n_vec = 0;
  int          n_fail = 0;
  bit          chk_en = 1'b0;
  logic [1:0]  m_ch;
  logic [15:0] m_fcnt;
  logic        m_err;
  int          dly1[4];
  int          dly2[4];
  int          due1[4];
  int          due2[4];
  int          cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t dut_vec();
    return {irst_s, shr_s, intg_s, shs_s, sti_s, clkr_s, start_adc, ch_index, frame_cnt,
            frame_done, busy, timeout_err};
  endfunction

  function automatic vec_t idle_v();
    vec_t v = '0;
    v.ch   = m_ch;
    v.fcnt = m_fcnt;
    v.err  = m_err;
    return v;
  endfunction

  function automatic vec_t base();
    vec_t v = idle_v();
    v.busy = 1'b1;
    return v;
  endfunction

  // Conversion length: one cycle past the last node's first valid (delay >= 1) pulse,
  // capped at the timeout when some node is late or silent.
  function automatic int conv_len(output bit tmo);
    int mx;
    int t;
    mx  = 0;
    tmo = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t = -1;
      if (dly1[i] >= 1) t = dly1[i];
      if (dly2[i] >= 1 && (t < 0 || dly2[i] < t)) t = dly2[i];
      if (t < 0) tmo = 1'b1;
      else if (t > mx) mx = t;
    end
    if (tmo || mx >= TMO) begin
      tmo = 1'b1;
      return TMO;
    end
    return mx + 1;
  endfunction

  task automatic push_n(input int n, input vec_t v);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic gen_frame(input int intg, output int len);
    int   n0;
    int   cl;
    bit   tmo;
    vec_t v;
    n0 = exp_q.size();
    v = base(); v.irst = 1'b1; push_n(RSTC, v);
    v = base(); v.shr = 1'b1;  push_n(SHC, v);
    v = base(); v.intg = 1'b1; push_n((intg < 1) ? 1 : intg, v);
    v = base(); v.shs = 1'b1;  push_n(SHC, v);
    m_ch = 2'd0;
    v = base(); v.sti = 1'b1; v.clkr = 1'b1; push_n(1, v);
    cl = conv_len(tmo);
    for (int c = 0; c < NCH; c++) begin
      push_n(STL, base());
      v = base(); v.start = 4'hF; push_n(1, v);
      push_n(cl - 1, base());
      if (tmo) m_err = 1'b1;
      if (c < NCH - 1) begin
        m_ch = m_ch + 2'd1;
        v = base(); v.clkr = 1'b1; push_n(1, v);
      end
    end
    m_fcnt = m_fcnt + 16'd1;
    v = base(); v.fdone = 1'b1; push_n(1, v);
    len = exp_q.size() - n0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    vec_t e;
    vec_t a;
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = idle_v();
      a = dut_vec();
      n_vec++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle %0d: dut %h, model %h", cyc, a, e);
      end
    end
  end

  // ADC responder: node i pulses dly1[i]/dly2[i] cycles after the start_adc cycle (-1 = never).
  initial begin
    adc_done = 4'h0;
    for (int i = 0; i < 4; i++) begin
      due1[i] = -100;
      due2[i] = -100;
    end
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < 4; i++) adc_done[i] = (cyc == due1[i]) || (cyc == due2[i]);
      @(negedge clk);
      if (start_adc == 4'hF) begin
        for (int i = 0; i < 4; i++) begin
          due1[i] = (dly1[i] >= 0) ? cyc + dly1[i] : -100;
          due2[i] = (dly2[i] >= 0) ? cyc + dly2[i] : -100;
          if (dly1[i] == 0 || dly2[i] == 0) adc_done[i] = 1'b1;
        end
      end
    end
  end

  task automatic set_dly(input int a0, input int a1, input int a2, input int a3,
                         input int b0, input int b1, input int b2, input int b3);
    dly1[0] = a0; dly1[1] = a1; dly1[2] = a2; dly1[3] = a3;
    dly2[0] = b0; dly2[1] = b1; dly2[2] = b2; dly2[3] = b3;
  endtask

  task automatic wait_q_le(input int n);
    for (int k = 0; k < 4000; k++) begin
      if (exp_q.size() <= n) return;
      @(posedge clk);
    end
    n_vec++;
    n_fail++;
    $display("FAIL wait_timeout: queue %0d, want <= %0d", exp_q.size(), n);
  endtask

  task automatic start_run();
    @(posedge clk);
    #1;
    run = 1'b1;
    exp_q.push_back(idle_v());
  endtask

  task automatic drop_run_after(input int n);
    wait_q_le(n);
    @(posedge clk);
    #1;
    run = 1'b0;
  endtask

  task automatic drain();
    wait_q_le(0);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic single_frame(input int intg, input int want_len, input string name);
    int len;
    intg_cyc = 16'(intg);
    start_run();
    gen_frame(intg, len);
    check(name, 32'(len), 32'(want_len));
    drop_run_after(len - 5);
    drain();
  endtask

  initial begin
    int l1, l2, l3, len;
    reset_n  = 1'b0;
    run      = 1'b0;
    intg_cyc = 16'd10;
    m_ch     = '0;
    m_fcnt   = '0;
    m_err    = 1'b0;
    set_dly(3, 3, 3, 3, -1, -1, -1, -1);
    #12;
    check("reset_outputs", 32'(dut_vec()), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_en  = 1'b1;

    single_frame(10, 47, "len_basic");
    check("fcnt_frame1", 32'(frame_cnt), 32'd1);
    check("busy_idle", 32'(busy), 32'd0);

    set_dly(1, 5, 9, 2, -1, -1, -1, -1);
    single_frame(10, 71, "len_stagger");

    // Coincident pulses dropped; node 1 answers twice.
    set_dly(0, 1, 2, 2, 3, 2, -1, -1);
    single_frame(10, 47, "len_coincident");

    set_dly(3, 3, -1, 3, -1, -1, -1, -1);
    single_frame(10, 111, "len_timeout");
    check("timeout_set", 32'(timeout_err), 32'd1);

    set_dly(3, 3, 3, 3, -1, -1, -1, -1);
    single_frame(10, 47, "len_after_timeout");
    check("timeout_sticky", 32'(timeout_err), 32'd1);
    check("fcnt_frame5", 32'(frame_cnt), 32'd5);

    intg_cyc = 16'd10;
    start_run();
    gen_frame(10, len);
    wait_q_le(len - 9);
    @(posedge clk);
    #1;
    chk_en  = 1'b0;
    reset_n = 1'b0;
    run     = 1'b0;
    #1;
    check("reset_mid_frame", 32'(dut_vec()), 32'h0);
    exp_q.delete();
    m_ch   = '0;
    m_fcnt = '0;
    m_err  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_en  = 1'b1;

    intg_cyc = 16'd10;
    start_run();
    gen_frame(10, l1);
    gen_frame(10, l2);
    gen_frame(5, l3);
    check("len_intg5", 32'(l3), 32'd42);
    wait_q_le(l2 + l3 - 10);
    @(posedge clk);
    #1;
    intg_cyc = 16'd5;
    drop_run_after(l3 - 5);
    drain();
    check("fcnt_three_frames", 32'(frame_cnt), 32'd3);

    single_frame(0, 38, "len_intg0");
    check("fcnt_frame4", 32'(frame_cnt), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
